// File: rtl/logic_unit_pkg.sv
// +----------------------------------------------------------------------+
// | logic_unit_pkg: op codes and FSM states for logic_accum_unit. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bitwise_op_alu.sv
// +----------------------------------------------------------------------+
// | bitwise_op_alu: combinational eight-way bitwise operator. Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module bitwise_op_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/logic_accum_unit.sv
// +----------------------------------------------------------------------+
// | logic_accum_unit: registered bitwise unit with burst accumulate.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module logic_accum_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [2:0]       acc_op;
  logic [CNT_W-1:0] cnt;

  logic             in_xfer;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = ~out_valid | out_ready;
  assign in_xfer  = in_valid & in_ready;

  // Mid-burst the ALU folds the running value with the incoming stream beat.
  assign alu_a  = (state == ACCUM) ? acc    : in_a;
  assign alu_b  = (state == ACCUM) ? in_a   : in_b;
  assign alu_op = (state == ACCUM) ? acc_op : in_op;

  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  bitwise_op_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_op    <= OP_AND;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_xfer) begin
        case (state)
          IDLE: begin
            if (!in_acc) begin
              out_data  <= alu_y;
              out_zero  <= (alu_y == '0);
              out_count <= CNT_W'(1);
              out_valid <= 1'b1;
            end else if (in_last) begin
              out_data  <= in_a;
              out_zero  <= (in_a == '0);
              out_count <= CNT_W'(1);
              out_valid <= 1'b1;
            end else begin
              acc    <= in_a;
              acc_op <= in_op;
              cnt    <= CNT_W'(1);
              state  <= ACCUM;
            end
          end
          ACCUM: begin
            if (in_last) begin
              out_data  <= alu_y;
              out_zero  <= (alu_y == '0);
              out_count <= cnt_inc;
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              acc <= alu_y;
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logic_accum_unit.sv
// +----------------------------------------------------------------------+
// | tb_logic_accum_unit: directed self-checking bench. Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_logic_accum_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_acc;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic [7:0] out_count;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [7:0] sat_out_data;
  logic       sat_out_zero;
  logic [1:0] sat_out_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_accum_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_count(out_count)
  );

  logic_accum_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_zero(sat_out_zero), .out_count(sat_out_count)
  );

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic acc, input logic last);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", out_zero); end
    n_checks++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_truth_sweep();
    logic [7:0] exp_tbl [8];
    exp_tbl[0] = 8'h30; exp_tbl[1] = 8'hFC; exp_tbl[2] = 8'hCC; exp_tbl[3] = 8'hCF;
    exp_tbl[4] = 8'h03; exp_tbl[5] = 8'h33; exp_tbl[6] = 8'hF0; exp_tbl[7] = 8'h0F;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_tbl[i-1] || out_count !== 8'd1) begin
          n_fail++; $display("FAIL truth_op%0d got v=%b d=%h c=%0d exp v=1 d=%h c=1", i-1, out_valid, out_data, out_count, exp_tbl[i-1]);
        end
      end
      if (i < 8) drive(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL truth_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_or_burst();
    logic [7:0] beats [4];
    beats[0] = 8'h01; beats[1] = 8'h02; beats[2] = 8'h04; beats[3] = 8'h80;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_quiet%0d got=%b exp=0", i, out_valid); end
      end
      drive(1'b1, beats[i], 8'h00, 3'd1, 1'b1, (i == 3));
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h87 || out_count !== 8'd4) begin
      n_fail++; $display("FAIL or_burst got v=%b d=%h c=%0d exp v=1 d=87 c=4", out_valid, out_data, out_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hAA, 8'h00, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h03 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp v=1 d=03 rdy=0", i, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hAA || out_count !== 8'd1) begin
      n_fail++; $display("FAIL bp_next got v=%b d=%h c=%0d exp v=1 d=AA c=1", out_valid, out_data, out_count);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_and_one_beat();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h5A, 8'h00, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h5A, 8'h00, 3'd2, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h77, 8'h00, 3'd2, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_zero !== 1'b1 || out_count !== 8'd2) begin
      n_fail++; $display("FAIL xor_zero got v=%b d=%h z=%b c=%0d exp v=1 d=00 z=1 c=2", out_valid, out_data, out_zero, out_count);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h77 || out_zero !== 1'b0 || out_count !== 8'd1) begin
      n_fail++; $display("FAIL one_beat got v=%b d=%h z=%b c=%0d exp v=1 d=77 z=0 c=1", out_valid, out_data, out_zero, out_count);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 8'hFF, 8'h00, 3'd0, 1'b1, (i == 5));
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++; if (sat_out_valid !== 1'b1 || sat_out_data !== 8'hFF || sat_out_count !== 2'd3 || sat_out_zero !== 1'b0) begin
      n_fail++; $display("FAIL sat_cnt2 got v=%b d=%h c=%0d exp v=1 d=FF c=3", sat_out_valid, sat_out_data, sat_out_count);
    end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_count !== 8'd6) begin
      n_fail++; $display("FAIL sat_cnt8 got v=%b d=%h c=%0d exp v=1 d=FF c=6", out_valid, out_data, out_count);
    end
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h0F, 8'h00, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hF0, 8'h00, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got v=%b c=%0d rdy=%b exp v=0 c=0 rdy=1", out_valid, out_count, in_ready);
    end
    drive(1'b1, 8'h01, 8'h10, 3'd1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_count !== 8'd1) begin
      n_fail++; $display("FAIL rst_single got v=%b d=%h c=%0d exp v=1 d=11 c=1", out_valid, out_data, out_count);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_truth_sweep();
    test_or_burst();
    test_back_to_back();
    test_zero_and_one_beat();
    test_saturation();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
